compound_multicast_producer: RTL and testbench

Parametrised successor to the single-output compound-message producer. It accepts one compound message (mode, x, y) on a blocking input and delivers derived copies to `NUM_CH` blocking output channels. Delivery is unicast in `read` mode and multicast in `write` mode. After every delivered message it emits a one-cycle summary on a non-blocking master output. It sits between a message source and `NUM_CH` blocking consumers, and uses the same notify/sync handshake as the rest of the generated blocks.

---
 rtl/compound_multicast_producer_pkg.sv | 27 ++
 rtl/compound_out_slot.sv | 51 +++++
 rtl/compound_multicast_producer.sv | 130 +++++++++++++
 tb/tb_compound_multicast_producer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/compound_multicast_producer_pkg.sv
// Shared types for the compound multicast producer: message mode, section enum
// and bit offsets of the compound word {mode, x, y}.
package compound_multicast_types;

    typedef enum logic {
        read  = 1'b0,
        write = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        SEC_READ   = 2'd0,
        SEC_SEND   = 2'd1,
        SEC_REPORT = 2'd2
    } section_e;

    localparam int unsigned Y_BIT = 0;
    localparam int unsigned X_LSB = 1;

    function automatic int unsigned mode_bit(input int unsigned x_width);
        return x_width + 1;
    endfunction

    function automatic int unsigned cw(input int unsigned x_width);
        return x_width + 2;
    endfunction

endpackage

// File: rtl/compound_out_slot.sv
// One blocking output channel: holds the derived data word and its pending bit,
// which is also the channel's registered notify.
module compound_out_slot
    import compound_multicast_types::*;
#(
    parameter  int unsigned X_WIDTH = 32,
    parameter  int unsigned CH_IDX  = 0,
    localparam int unsigned CW      = cw(X_WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  mode_e              msg_mode,
    input  logic [X_WIDTH-1:0] msg_x,
    input  logic               msg_y,
    input  logic               sync,
    output logic [CW-1:0]      data,
    output logic               notify
);

    logic [CW-1:0] data_q;
    logic [CW-1:0] data_d;
    logic          pending_q;
    logic          pending_d;

    // A load always wins over a same-cycle sync; a sync on an idle slot is ignored.
    always_comb begin
        data_d    = data_q;
        pending_d = pending_q;
        if (load) begin
            data_d    = {msg_mode, msg_x + X_WIDTH'(CH_IDX), ~msg_y};
            pending_d = 1'b1;
        end else if (sync && pending_q) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            pending_q <= pending_d;
        end
    end

    assign data   = data_q;
    assign notify = pending_q;

endmodule

// File: rtl/compound_multicast_producer.sv
// Accepts one compound message and delivers derived copies to NUM_CH channels
// (unicast for read, multicast for write), then pulses a one-cycle summary.
module compound_multicast_producer
    import compound_multicast_types::*;
#(
    parameter  int unsigned NUM_CH  = 4,
    parameter  int unsigned X_WIDTH = 32,
    localparam int unsigned CH_W    = $clog2(NUM_CH),
    localparam int unsigned CW      = cw(X_WIDTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CW-1:0]              b_in,
    input  logic                       b_in_sync,
    output logic                       b_in_notify,
    output logic [NUM_CH-1:0][CW-1:0]  b_out,
    input  logic [NUM_CH-1:0]          b_out_sync,
    output logic [NUM_CH-1:0]          b_out_notify,
    output logic [CW-1:0]              m_out,
    output logic                       m_out_notify
);

    localparam int unsigned MODE_BIT = mode_bit(X_WIDTH);
    localparam logic [X_WIDTH-1:0] MULTI_COUNT = X_WIDTH'(NUM_CH);
    localparam logic [X_WIDTH-1:0] UNI_COUNT   = X_WIDTH'(1);

    section_e           state_q;
    section_e           state_d;
    mode_e              mode_q;
    mode_e              mode_d;
    logic               b_in_notify_q;
    logic               b_in_notify_d;
    logic [CW-1:0]      m_out_q;
    logic [CW-1:0]      m_out_d;
    logic               m_out_notify_q;
    logic               m_out_notify_d;

    mode_e              in_mode;
    logic [X_WIDTH-1:0] in_x;
    logic               in_y;
    logic               in_xfer;
    logic [NUM_CH-1:0]  sel;
    logic [NUM_CH-1:0]  load;
    logic [NUM_CH-1:0]  pending;
    logic [NUM_CH-1:0]  remaining;

    assign in_mode   = mode_e'(b_in[MODE_BIT]);
    assign in_x      = b_in[X_LSB +: X_WIDTH];
    assign in_y      = b_in[Y_BIT];
    assign in_xfer   = b_in_notify_q && b_in_sync;
    assign remaining = pending & ~b_out_sync;

    // Channel mask: one-hot on the low x bits for read, every channel for write.
    always_comb begin
        sel = '0;
        if (in_mode == write) begin
            sel = '1;
        end else begin
            sel[in_x[CH_W-1:0]] = 1'b1;
        end
        load = in_xfer ? sel : '0;
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_slot
        compound_out_slot #(
            .X_WIDTH (X_WIDTH),
            .CH_IDX  (c)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .load     (load[c]),
            .msg_mode (in_mode),
            .msg_x    (in_x),
            .msg_y    (in_y),
            .sync     (b_out_sync[c]),
            .data     (b_out[c]),
            .notify   (pending[c])
        );
    end

    // Section FSM; registered outputs are derived from the next section.
    always_comb begin
        state_d        = state_q;
        mode_d         = mode_q;
        m_out_d        = m_out_q;
        m_out_notify_d = 1'b0;
        case (state_q)
            SEC_READ: begin
                if (in_xfer) begin
                    mode_d  = in_mode;
                    state_d = SEC_SEND;
                end
            end
            SEC_SEND: begin
                if (remaining == '0) begin
                    state_d        = SEC_REPORT;
                    m_out_notify_d = 1'b1;
                    m_out_d        = {mode_q,
                                      (mode_q == write) ? MULTI_COUNT : UNI_COUNT,
                                      mode_q == write};
                end
            end
            SEC_REPORT: state_d = SEC_READ;
            default:    state_d = SEC_READ;
        endcase
        b_in_notify_d = (state_d == SEC_READ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= SEC_READ;
            mode_q         <= read;
            b_in_notify_q  <= 1'b1;
            m_out_q        <= '0;
            m_out_notify_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            mode_q         <= mode_d;
            b_in_notify_q  <= b_in_notify_d;
            m_out_q        <= m_out_d;
            m_out_notify_q <= m_out_notify_d;
        end
    end

    assign b_in_notify  = b_in_notify_q;
    assign b_out_notify = pending;
    assign m_out        = m_out_q;
    assign m_out_notify = m_out_notify_q;

endmodule

// File: tb/tb_compound_multicast_producer.sv
// Randomized self-checking bench for compound_multicast_producer with a
// transaction-level model of channel selection, delivery and summary.
module tb_compound_multicast_producer;

    localparam int unsigned NUM_CH  = 4;
    localparam int unsigned X_WIDTH = 32;
    localparam int unsigned CW      = X_WIDTH + 2;

    logic                      clk;
    logic                      rst;
    logic [CW-1:0]             b_in;
    logic                      b_in_sync;
    logic                      b_in_notify;
    logic [NUM_CH-1:0][CW-1:0] b_out;
    logic [NUM_CH-1:0]         b_out_sync;
    logic [NUM_CH-1:0]         b_out_notify;
    logic [CW-1:0]             m_out;
    logic                      m_out_notify;

    int n_checks = 0;
    int n_errors = 0;

    logic [CW-1:0]     exp_data [NUM_CH];
    logic [NUM_CH-1:0] sync_script [$];

    compound_multicast_producer #(
        .NUM_CH  (NUM_CH),
        .X_WIDTH (X_WIDTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .b_in         (b_in),
        .b_in_sync    (b_in_sync),
        .b_in_notify  (b_in_notify),
        .b_out        (b_out),
        .b_out_sync   (b_out_sync),
        .b_out_notify (b_out_notify),
        .m_out        (m_out),
        .m_out_notify (m_out_notify)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_data(input string tag);
        for (int c = 0; c < NUM_CH; c++)
            check($sformatf("%s_data%0d", tag, c), 64'(b_out[c]), 64'(exp_data[c]));
    endtask

    // One full message: wait for ready, transfer, drive syncs, check summary.
    task automatic send_msg(input logic mode, input logic [X_WIDTH-1:0] x, input logic y);
        logic [NUM_CH-1:0] sel;
        logic [NUM_CH-1:0] pend;
        logic [NUM_CH-1:0] s;
        logic [CW-1:0]     exp_sum;
        int                waited;
        bit                done;

        waited = 0;
        while (b_in_notify !== 1'b1 && waited < 10) begin
            step();
            waited++;
        end
        check("in_ready", 64'(b_in_notify), 64'(1));

        b_in       = {mode, x, y};
        b_in_sync  = 1'b1;
        b_out_sync = NUM_CH'($urandom);
        sel = '0;
        if (mode) sel = '1;
        else      sel[x[1:0]] = 1'b1;
        step();

        b_in_sync  = 1'b0;
        b_in       = CW'({$urandom, $urandom});
        for (int c = 0; c < NUM_CH; c++)
            if (sel[c]) exp_data[c] = {mode, x + X_WIDTH'(c), ~y};
        check("load_notify", 64'(b_out_notify), 64'(sel));
        check("load_in_busy", 64'(b_in_notify), 64'(0));
        check("load_no_sum", 64'(m_out_notify), 64'(0));
        check_data("load");

        pend    = sel;
        done    = 1'b0;
        exp_sum = {mode, X_WIDTH'(mode ? NUM_CH : 1), mode};
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            if (sync_script.size() > 0) s = sync_script.pop_front();
            else if (cyc >= 20)         s = '1;
            else                        s = NUM_CH'($urandom);
            b_out_sync = s;
            b_in_sync  = 1'($urandom);
            step();
            pend = pend & ~s;
            if (pend == '0) begin
                done = 1'b1;
                check("sum_pulse", 64'(m_out_notify), 64'(1));
                check("sum_word", 64'(m_out), 64'(exp_sum));
                check("sum_notify_clear", 64'(b_out_notify), 64'(0));
                check("sum_in_busy", 64'(b_in_notify), 64'(0));
            end else begin
                check("send_notify", 64'(b_out_notify), 64'(pend));
                check("send_no_sum", 64'(m_out_notify), 64'(0));
                check("send_in_busy", 64'(b_in_notify), 64'(0));
            end
        end
        check("delivered", 64'(done), 64'(1));
        sync_script.delete();

        b_out_sync = '0;
        b_in_sync  = 1'b0;
        step();
        check("post_sum_low", 64'(m_out_notify), 64'(0));
        check("post_in_ready", 64'(b_in_notify), 64'(1));
        check("post_notify", 64'(b_out_notify), 64'(0));
        check_data("post");
    endtask

    initial begin
        rst        = 1'b1;
        b_in       = '0;
        b_in_sync  = 1'b0;
        b_out_sync = '0;
        for (int c = 0; c < NUM_CH; c++) exp_data[c] = '0;

        step();
        step();
        rst = 1'b0;

        // Reset state and idle hold.
        check("rst_m_out", 64'(m_out), 64'(0));
        check_data("rst");
        for (int i = 0; i < 10; i++) begin
            check("idle_in_ready", 64'(b_in_notify), 64'(1));
            check("idle_out_notify", 64'(b_out_notify), 64'(0));
            check("idle_sum", 64'(m_out_notify), 64'(0));
            step();
        end

        // Unicast to channel 2 with spurious syncs, delivery at T+3.
        sync_script.push_back(4'b1011);
        sync_script.push_back(4'b0000);
        sync_script.push_back(4'b0100);
        send_msg(1'b0, 32'd6, 1'b0);
        check("uni_ch2", 64'(b_out[2]), 64'({1'b0, 32'd8, 1'b1}));

        // Multicast with x wrap, staggered completion 3, 0, then 1 and 2.
        sync_script.push_back(4'b1000);
        sync_script.push_back(4'b0001);
        sync_script.push_back(4'b0110);
        send_msg(1'b1, 32'hFFFF_FFFE, 1'b1);
        check("wrap_ch0", 64'(b_out[0]), 64'({1'b1, 32'hFFFF_FFFE, 1'b0}));
        check("wrap_ch1", 64'(b_out[1]), 64'({1'b1, 32'hFFFF_FFFF, 1'b0}));
        check("wrap_ch2", 64'(b_out[2]), 64'({1'b1, 32'h0000_0000, 1'b0}));
        check("wrap_ch3", 64'(b_out[3]), 64'({1'b1, 32'h0000_0001, 1'b0}));

        // Minimum period: all selected channels accept immediately.
        sync_script.push_back(4'b1111);
        send_msg(1'b1, 32'h0000_1000, 1'b0);

        // Randomized messages.
        for (int i = 0; i < 40; i++)
            send_msg(1'($urandom), $urandom, 1'($urandom));

        // Reset during partial multicast delivery.
        b_in      = {1'b1, 32'h1234_5678, 1'b0};
        b_in_sync = 1'b1;
        step();
        b_in_sync  = 1'b0;
        b_out_sync = 4'b0001;
        step();
        check("abort_partial", 64'(b_out_notify), 64'(4'b1110));
        b_out_sync = '0;
        rst        = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < NUM_CH; c++) exp_data[c] = '0;
        check("abort_notify", 64'(b_out_notify), 64'(0));
        check("abort_in_ready", 64'(b_in_notify), 64'(1));
        check("abort_sum", 64'(m_out_notify), 64'(0));
        check("abort_m_out", 64'(m_out), 64'(0));
        check_data("abort");
        for (int i = 0; i < 3; i++) begin
            b_out_sync = NUM_CH'($urandom);
            step();
            check("abort_quiet_sum", 64'(m_out_notify), 64'(0));
            check("abort_quiet_ready", 64'(b_in_notify), 64'(1));
            check("abort_quiet_notify", 64'(b_out_notify), 64'(0));
        end
        b_out_sync = '0;

        // Recovery after reset.
        send_msg(1'b0, 32'h0000_0003, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
